pulse_period_monitor: RTL and testbench
=======================================

Name: pulse_period_monitor

Overview:
- Receiver-side checker for a periodic one-cycle pulse from a delay/period generator (e.g. a pulse every 25001 cycles).
- Measures the interval between pulses and locks after a run of in-window intervals.
- Flags early pulses (safety) and missing/late pulses (liveness) with sticky errors.
- Sits beside the generator in safety/liveness checking subsystems.

Parameters:
- PERIOD, 25001, expected interval in clk cycles between pulse_in high cycles.
- TOL, 2, allowed deviation either side of PERIOD. Must satisfy TOL < PERIOD.
- LOCK_N, 4, consecutive good intervals required to lock (>=1).
- CBITS, 16, counter width. Must satisfy 2^CBITS-1 >= PERIOD+TOL+1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pulse_in  in  1  monitored pulse, synchronous to clk
- clr  in  1  synchronous clear of state and sticky errors
- locked  out  1  high in LOCKED state
- early_err  out  1  sticky: pulse arrived before window
- late_err  out  1  sticky: no pulse by end of window
- fault  out  1  early_err | late_err
- meas_valid  out  1  one-cycle strobe, a new interval was measured
- meas_period  out  CBITS  last measured interval

Behaviour:
- Reset: rst asserted takes effect immediately (async). State=IDLE, cnt=0, and all outputs are 0.
- Interval counter cnt:
  - On a pulse cycle, the measured interval is cnt, and cnt is loaded with 1.
  - Otherwise cnt increments, saturating at all-ones.
  - Back-to-back pulses measure 1.
- Window:
  - good: PERIOD-TOL <= meas <= PERIOD+TOL
  - early: meas < PERIOD-TOL
  - timeout: cnt == PERIOD+TOL and pulse_in=0 in the same cycle
- A pulse exactly at PERIOD+TOL is good and takes priority over timeout.
- States IDLE, SYNC, LOCKED, FAULT. All transitions take effect at the next edge.
  - IDLE: pulse → SYNC, cnt=1, no measurement.
  - SYNC:
    - good pulse: run++. If run reaches LOCK_N → LOCKED.
    - early pulse: run=0, stay SYNC, counter restarts.
    - timeout: → IDLE, run=0, no error.
  - LOCKED:
    - good pulse: stay.
    - early pulse: → FAULT, early_err=1.
    - timeout: → FAULT, late_err=1.
  - FAULT:
    - Ignores pulse_in and keeps errors; only clr leaves.
    - cnt keeps running, saturating.
- clr in any state: next state IDLE, run=0, cnt=0, errors=0, locked=0. clr has priority over a simultaneous pulse, timeout or lock.
- Output timing:
  - meas_valid/meas_period are registered, one cycle after the pulse, in SYNC/LOCKED only.
  - meas_period holds between strobes.
  - locked/errors are registered and reflect the state after the edge.
- run counter: clog2(LOCK_N+1) bits, never wraps.

Optional Feature:
- Macro: PPM_FAULT_CNT_EN.
- Defined:
  - Adds output fault_cnt [7:0].
  - Increments on every early or timeout event in SYNC or LOCKED, including SYNC early/timeout that do not set errors.
  - Saturates at 255. Cleared by rst or clr.
- Undefined: port absent, no counter logic, behaviour otherwise identical.

Decomposition:
- Package ppm_pkg:
  - state typedef enum {IDLE, SYNC, LOCKED, FAULT}
  - default constants for PERIOD/TOL/LOCK_N
  - helper function for window classification
- Sub-module ppm_interval_counter:
  - saturating cnt with load-on-pulse
  - good/early/timeout decode
  - instantiated once. The FSM and output registers stay in the top.

Test Plan (PERIOD=10, TOL=1, LOCK_N=3):
- Reset, then pulses every 10 cycles ×5 → meas_valid strobes with meas_period=10; locked=1 the cycle after the 4th pulse's edge.
- Locked, next pulse 8 cycles after previous → early_err=1, fault=1, locked=0; later pulses produce no meas_valid.
- Locked, no pulse → late_err=1 on the edge after cnt==11 with pulse_in=0, no earlier.
- Locked, intervals 11, 9, 11 → no error, meas_period 11/9/11, locked stays 1.
- FAULT, clr and pulse_in high in the same cycle → IDLE, errors cleared, that pulse ignored. Relock needs 1+3 more pulses.
- Locked, rst asserted between edges → all outputs 0 before the next clk edge. With PPM_FAULT_CNT_EN, fault_cnt=0.

Source files
------------

// File: rtl/ppm_pkg.sv
// ppm_pkg: shared state/window types, default parameters and window classifier
// for pulse_period_monitor.
package ppm_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;
    typedef enum logic [1:0] {W_NONE, W_GOOD, W_EARLY, W_LATE} win_t;

    localparam int DEF_PERIOD = 25001;
    localparam int DEF_TOL    = 2;
    localparam int DEF_LOCK_N = 4;

    // A pulse exactly at period+tol is good, so the pulse branch wins over timeout.
    function automatic win_t classify(input logic pulse, input int cnt, input int period, input int tol);
        return pulse ? ((cnt < period - tol) ? W_EARLY : (cnt <= period + tol) ? W_GOOD : W_NONE)
                     : ((cnt == period + tol) ? W_LATE : W_NONE);
    endfunction

endpackage

// File: rtl/ppm_interval_counter.sv
// ppm_interval_counter: saturating interval counter with load-on-pulse and
// good/early/timeout decode of the current interval.
module ppm_interval_counter
    import ppm_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int TOL    = DEF_TOL,
    parameter int CBITS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    output logic [CBITS-1:0] cnt,
    output logic             good,
    output logic             early,
    output logic             timeout
);

    win_t win;

    assign win     = classify(load, 32'(cnt), PERIOD, TOL);
    assign good    = (win == W_GOOD);
    assign early   = (win == W_EARLY);
    assign timeout = (win == W_LATE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CBITS'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: locks onto a periodic one-cycle pulse and flags early/late pulses.
// Optional PPM_FAULT_CNT_EN adds an 8-bit saturating count of early/timeout events.
module pulse_period_monitor
    import ppm_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int TOL    = DEF_TOL,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int CBITS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clr,
    output logic             locked,
    output logic             early_err,
    output logic             late_err,
    output logic             fault,
    output logic             meas_valid,
    output logic [CBITS-1:0] meas_period
`ifdef PPM_FAULT_CNT_EN
    ,
    output logic [7:0]       fault_cnt
`endif
);

    localparam int RW = $clog2(LOCK_N + 1);

    state_t           state;
    logic [RW-1:0]    run;
    logic [CBITS-1:0] cnt;
    logic             good, early, timeout;

    // FAULT freezes measurement: pulses there must not restart the interval.
    ppm_interval_counter #(.PERIOD(PERIOD), .TOL(TOL), .CBITS(CBITS)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .load    (pulse_in && state != FAULT),
        .cnt     (cnt),
        .good    (good),
        .early   (early),
        .timeout (timeout)
    );

    assign locked = (state == LOCKED);
    assign fault  = early_err | late_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            run         <= '0;
            early_err   <= 1'b0;
            late_err    <= 1'b0;
            meas_valid  <= 1'b0;
            meas_period <= '0;
        end else begin
            meas_valid <= 1'b0;
            if (clr) begin
                state     <= IDLE;
                run       <= '0;
                early_err <= 1'b0;
                late_err  <= 1'b0;
            end else begin
                if (pulse_in && (state == SYNC || state == LOCKED)) begin
                    meas_valid  <= 1'b1;
                    meas_period <= cnt;
                end
                case (state)
                    IDLE: begin
                        run <= '0;
                        if (pulse_in) state <= SYNC;
                    end
                    SYNC: begin
                        if (good) begin
                            run <= run + 1'b1;
                            if (run == RW'(LOCK_N - 1)) state <= LOCKED;
                        end else if (early) begin
                            run <= '0;
                        end else if (timeout) begin
                            run   <= '0;
                            state <= IDLE;
                        end
                    end
                    LOCKED: begin
                        if (early) begin
                            state     <= FAULT;
                            early_err <= 1'b1;
                        end else if (timeout) begin
                            state    <= FAULT;
                            late_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PPM_FAULT_CNT_EN
    logic ev;

    assign ev = (state == SYNC || state == LOCKED) && (early || timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt <= '0;
        end else if (clr) begin
            fault_cnt <= '0;
        end else if (ev && fault_cnt != 8'hFF) begin
            fault_cnt <= fault_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor: directed + random pulse trains against a timestamp-based
// reference model of the period monitor.
module tb_pulse_period_monitor;

    localparam int PERIOD = 10;
    localparam int TOL    = 1;
    localparam int LOCK_N = 3;
    localparam int CBITS  = 5;
    localparam int CMAX   = (1 << CBITS) - 1;

    logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0, clr = 1'b0;
    logic locked, early_err, late_err, fault, meas_valid;
    logic [CBITS-1:0] meas_period;
`ifdef PPM_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    pulse_period_monitor #(.PERIOD(PERIOD), .TOL(TOL), .LOCK_N(LOCK_N), .CBITS(CBITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .clr         (clr),
        .locked      (locked),
        .early_err   (early_err),
        .late_err    (late_err),
        .fault       (fault),
        .meas_valid  (meas_valid),
        .meas_period (meas_period)
`ifdef PPM_FAULT_CNT_EN
        ,
        .fault_cnt   (fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_HUNT, M_LOCK, M_FAIL} mode_t;

    int    checks = 0, errors = 0;
    int    cyc = 0, zt = 0, run = 0, e_per = 0, e_fcnt = 0;
    bit    e_valid, e_early, e_late;
    mode_t mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE; zt = cyc; run = 0; e_per = 0; e_fcnt = 0;
        e_valid = 0; e_early = 0; e_late = 0;
    endtask

    // Interval = cycles since the last accepted pulse (timestamp zt), clamped to CMAX.
    task automatic model(input bit p, input bit c);
        int n;
        bit good, early, late, active;
        n = cyc - zt;
        if (n > CMAX) n = CMAX;
        e_valid = 0;
        if (c) begin
            mode = M_IDLE; run = 0; e_early = 0; e_late = 0; e_fcnt = 0; zt = cyc + 1;
        end else begin
            good   = p && n >= PERIOD - TOL && n <= PERIOD + TOL;
            early  = p && n < PERIOD - TOL;
            late   = !p && n == PERIOD + TOL;
            active = (mode == M_HUNT || mode == M_LOCK);
            if (active && (early || late) && e_fcnt < 255) e_fcnt++;
            if (active && p) begin e_valid = 1; e_per = n; end
            if (p && mode != M_FAIL) zt = cyc;
            case (mode)
                M_IDLE: if (p) mode = M_HUNT;
                M_HUNT: begin
                    if (good) begin run++; if (run == LOCK_N) mode = M_LOCK; end
                    else if (early) run = 0;
                    else if (late) begin run = 0; mode = M_IDLE; end
                end
                M_LOCK: begin
                    if (early) begin mode = M_FAIL; e_early = 1; end
                    else if (late) begin mode = M_FAIL; e_late = 1; end
                end
                default: ;
            endcase
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("meas_valid", 32'(meas_valid), 32'(e_valid));
        chk("meas_period", 32'(meas_period), 32'(e_per));
        chk("locked", 32'(locked), 32'(mode == M_LOCK));
        chk("early_err", 32'(early_err), 32'(e_early));
        chk("late_err", 32'(late_err), 32'(e_late));
        chk("fault", 32'(fault), 32'(e_early | e_late));
`ifdef PPM_FAULT_CNT_EN
        chk("fault_cnt", 32'(fault_cnt), 32'(e_fcnt));
`endif
    endtask

    task automatic step(input bit p, input bit c);
        pulse_in = p;
        clr      = c;
        @(posedge clk);
        model(p, c);
        #1;
        check_all();
    endtask

    task automatic gap(input int n);
        for (int i = 1; i < n; i++) step(0, 0);
        step(1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic lock_up();
        step(1, 0);
        repeat (LOCK_N) gap(PERIOD);
        chk("lock_up", 32'(locked), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
        lock_up();
        gap(PERIOD);
        gap(PERIOD + TOL);
        gap(PERIOD - TOL);
        gap(PERIOD + TOL);
        gap(PERIOD - 2);
        chk("early_fault", 32'(early_err), 32'd1);
        gap(PERIOD);
        gap(PERIOD);
        step(1, 1);
        lock_up();
        idle(PERIOD + TOL + 40);
        chk("late_fault", 32'(late_err), 32'd1);
        step(0, 1);
        lock_up();
        #3 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      gap($urandom_range(PERIOD - TOL, PERIOD + TOL));
            else if (r < 80) gap($urandom_range(1, PERIOD - TOL - 1));
            else if (r < 88) gap($urandom_range(PERIOD + TOL + 1, 40));
            else if (r < 95) step(1'($urandom_range(0, 1)), 1);
            else             gap(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
